xb_msg_deframer: RTL and testbench
==================================

// Module: xb_msg_deframer
// PURPOSE
//  Generalised PC->FPGA command deframer. Sits between the xb_wr FIFO read side (FWFT, valid/ack) and
//  the application(s): pops MSG_WORDS words of XB_SIZE bits, assembles one wide command, steers it
//  to one of N_CHAN consumers by a channel field, and drops stale partial frames after a timeout.
//  Replaces per-application word counting of the fixed 3-word START/STOP frames.
// PARAMETERS
//  XB_SIZE    32  width of one xillybus word
//  MSG_WORDS   3  words per command frame (>=1)
//  N_CHAN      1  number of downstream consumers (>=1)
//  TIMEOUT  1024  idle cycles allowed between words of one frame; 0 disables the timeout
//  CNT_W      16  width of delivered-message counter
//  DELAY       1  simulation delay on registered assignments
// PORTS
//  CLK           in   1                  application clock; sole clock
//  RESET         in   1                  synchronous, active-high
//  pc_msg_valid  in   1                  FIFO has a word (NOT empty)
//  pc_msg        in   XB_SIZE            FIFO head word
//  pc_msg_ack    out  1                  pop FIFO head this cycle (rden)
//  msg_valid     out  N_CHAN             one-hot: command ready for channel c
//  msg           out  MSG_WORDS*XB_SIZE  assembled command, shared by all channels
//  msg_ready     in   N_CHAN             consumer c accepts command
//  timeout_err   out  1                  1-cycle pulse: partial frame discarded
//  chan_err      out  1                  1-cycle pulse: frame with channel >= N_CHAN discarded
//  msg_count     out  CNT_W              commands delivered since reset, wraps
// BEHAVIOUR
//  - Reset (RESET=1 at posedge): state=S_COLLECT, word index=0, timer=0, msg=0, msg_valid=0,
//    timeout_err=0, chan_err=0, msg_count=0. pc_msg_ack forced 0 while RESET=1. Reset mid-frame or
//    mid-delivery discards the frame; no msg_valid after reset.
//  - pc_msg_ack = pc_msg_valid && state==S_COLLECT && !RESET (combinational; FWFT FIFO).
//  - Word order: first word popped -> msg[XB_SIZE-1:0], word k -> msg[k*XB_SIZE +: XB_SIZE].
//  - Channel = word0[XB_SIZE-1 -: CHAN_BITS], CHAN_BITS = max(1, log2(N_CHAN)); N_CHAN=1 ignores it.
//  - S_COLLECT: on ack store word at index, index++. Popping word MSG_WORDS-1 (index wraps to 0):
//      channel < N_CHAN -> S_DELIVER, msg_valid[chan]=1 next cycle (latency 1 from last pop);
//      else stay S_COLLECT, chan_err pulses next cycle, frame dropped.
//  - S_DELIVER: msg and msg_valid held stable, no pops. When msg_ready[chan] && msg_valid[chan]:
//    msg_valid=0, msg_count++, S_COLLECT next cycle. msg_ready of other channels ignored.
//    Peak throughput: one frame per MSG_WORDS+1 cycles.
//  - Timeout (TIMEOUT>0): timer clears on every pop and while index==0; increments each S_COLLECT
//    cycle with index>0 and no pop. Reaching TIMEOUT-1 without a pop: index=0, timer=0, timeout_err
//    pulses next cycle. A pop in that same cycle wins (no timeout). Never active in S_DELIVER.
//  - MSG_WORDS=1: every pop is a complete frame; timeout never fires.
//  - msg_count wraps 2^CNT_W-1 -> 0 silently.
// STRUCTURE
//  - State encodings, `TRUE/`FALSE and log2() come from the shared function.v include.
//  - Single module; the timeout timer is generated only if TIMEOUT>0 (generate block, no sub-module).
// TESTING
//  - Reset defaults: hold RESET 4 cycles with pc_msg_valid=1 -> pc_msg_ack=0, all outputs 0.
//  - START frame (defaults): words 'h0000_0140,'h0012_0000,'h3c23_d70a back-to-back, msg_ready=1 ->
//    msg_valid[0]=1 one cycle after 3rd pop, msg='h3c23d70a_00120000_00000140, msg_count=1.
//  - Back-pressure: N_CHAN=4, word0='h4000_0000 (chan 1), msg_ready=0 for 10 cycles -> msg_valid=4'b0010
//    held stable, pc_msg_ack=0 throughout; release -> msg_count=1, next frame accepted.
//  - Bad channel: N_CHAN=3, word0='hC000_0000 (chan 3) -> no msg_valid, chan_err one pulse, next
//    good frame delivered normally.
//  - Timeout: TIMEOUT=16, pop 2 words then idle -> timeout_err pulse after 16 idle cycles; next 3
//    words form a complete frame; a 3rd word arriving on the timeout cycle completes the frame.
//  - Reset mid-delivery and counter wrap: CNT_W=2, deliver 5 frames -> msg_count=1; RESET while
//    msg_valid=1 -> msg_valid=0 next cycle, msg_count=0.

Source files
------------

// File: rtl/xb_msg_deframer_pkg.sv
// Purpose: shared constants and helpers for the xillybus command deframer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xb_msg_deframer_pkg;

  // Deframer FSM encodings
  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_DELIVER = 1'b1;

  // Width of the channel field: ceil(log2(n_chan)), but never less than one bit
  function automatic int chan_bits(input int n_chan);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n_chan) b = i + 1;
    end
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/xb_msg_deframer.sv
// Purpose: pop MSG_WORDS FWFT words, assemble one command, steer it one-hot by its channel field.
// Latency: msg_valid rises one cycle after the last word of a frame is popped.
// Backpressure: no pops while a command waits for msg_ready of its channel; stale partial frames time out.
module xb_msg_deframer
  import xb_msg_deframer_pkg::*;
#(
  parameter int XB_SIZE   = 32,
  parameter int MSG_WORDS = 3,
  parameter int N_CHAN    = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         pc_msg_valid,
  input  logic [XB_SIZE-1:0]           pc_msg,
  output logic                         pc_msg_ack,
  output logic [N_CHAN-1:0]            msg_valid,
  output logic [MSG_WORDS*XB_SIZE-1:0] msg,
  input  logic [N_CHAN-1:0]            msg_ready,
  output logic                         timeout_err,
  output logic                         chan_err,
  output logic [CNT_W-1:0]             msg_count
);

  localparam int CHAN_BITS = chan_bits(N_CHAN);
  localparam int IDX_W     = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MSG_WORDS - 1);
  localparam logic [CHAN_BITS:0] N_CHAN_L = (CHAN_BITS + 1)'(N_CHAN);

  logic [0:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [CHAN_BITS-1:0] chan;
  logic                 chan_ok;
  logic                 frame_done;
  logic                 timeout_hit;

  // FWFT: popping is simply acknowledging the head word while collecting
  assign pc_msg_ack = pc_msg_valid && (state == S_COLLECT) && !RESET;
  assign frame_done = pc_msg_ack && (idx == LAST_IDX);

  // Channel comes from word 0; with single-word frames that is the word being popped right now
  always_comb begin
    chan = '0;
    if (N_CHAN > 1) begin
      chan = (idx == '0) ? pc_msg[XB_SIZE-1 -: CHAN_BITS] : msg[XB_SIZE-1 -: CHAN_BITS];
    end
  end

  assign chan_ok = ({1'b0, chan} < N_CHAN_L);

  // Inter-word idle timer, only present when a timeout is configured and frames span several words
  generate
    if (TIMEOUT > 0 && MSG_WORDS > 1) begin : g_timer
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] timer;

      assign timeout_hit = (state == S_COLLECT) && (idx != '0) && !pc_msg_ack &&
                           (timer == TW'(TIMEOUT - 1));

      // Count idle cycles inside a partial frame; any pop, empty frame or expiry restarts it
      always_ff @(posedge CLK) begin
        if (RESET || pc_msg_ack || (idx == '0) || (state != S_COLLECT) || timeout_hit) begin
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end else begin : g_no_timer
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Frame assembly, delivery handshake, error pulses and delivered-command counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_COLLECT;
      idx         <= '0;
      msg         <= '0;
      msg_valid   <= '0;
      timeout_err <= 1'b0;
      chan_err    <= 1'b0;
      msg_count   <= '0;
    end else begin
      timeout_err <= 1'b0;
      chan_err    <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (pc_msg_ack) begin
            msg[int'(idx) * XB_SIZE +: XB_SIZE] <= pc_msg;
            if (frame_done) begin
              idx <= '0;
              if (chan_ok) begin
                state     <= S_DELIVER;
                msg_valid <= N_CHAN'(1) << chan;
              end else begin
                chan_err <= 1'b1;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (timeout_hit) begin
            idx         <= '0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          // Only the addressed channel's ready matters: msg_valid has a single bit set
          if (|(msg_valid & msg_ready)) begin
            msg_valid <= '0;
            msg_count <= msg_count + CNT_W'(1);
            state     <= S_COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xb_msg_deframer.sv
// Purpose: directed self-checking bench for xb_msg_deframer (single- and multi-channel builds).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises held msg_valid with ready withheld, then released.
module tb_xb_msg_deframer;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // Instance A: one channel, short timeout, 2-bit counter
  logic        a_vld;
  logic [31:0] a_dat;
  logic        a_ack;
  logic [0:0]  a_mv;
  logic [95:0] a_msg;
  logic [0:0]  a_rdy;
  logic        a_terr;
  logic        a_cerr;
  logic [1:0]  a_cnt;

  // Instance B: three channels, timeout disabled
  logic        b_vld;
  logic [31:0] b_dat;
  logic        b_ack;
  logic [2:0]  b_mv;
  logic [95:0] b_msg;
  logic [2:0]  b_rdy;
  logic        b_terr;
  logic        b_cerr;
  logic [15:0] b_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  xb_msg_deframer #(.XB_SIZE(32), .MSG_WORDS(3), .N_CHAN(1), .TIMEOUT(16), .CNT_W(2)) u_a (
    .CLK(CLK), .RESET(RESET), .pc_msg_valid(a_vld), .pc_msg(a_dat), .pc_msg_ack(a_ack),
    .msg_valid(a_mv), .msg(a_msg), .msg_ready(a_rdy), .timeout_err(a_terr),
    .chan_err(a_cerr), .msg_count(a_cnt)
  );

  xb_msg_deframer #(.XB_SIZE(32), .MSG_WORDS(3), .N_CHAN(3), .TIMEOUT(0), .CNT_W(16)) u_b (
    .CLK(CLK), .RESET(RESET), .pc_msg_valid(b_vld), .pc_msg(b_dat), .pc_msg_ack(b_ack),
    .msg_valid(b_mv), .msg(b_msg), .msg_ready(b_rdy), .timeout_err(b_terr),
    .chan_err(b_cerr), .msg_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_word(input logic [31:0] w);
    a_vld = 1'b1;
    a_dat = w;
    tick();
  endtask

  task automatic b_word(input logic [31:0] w);
    b_vld = 1'b1;
    b_dat = w;
    tick();
  endtask

  // Full frame on A with ready high: three pops, then one delivery cycle
  task automatic a_frame(input logic [31:0] w0);
    a_word(w0);
    a_word(w0 + 32'd1);
    a_word(w0 + 32'd2);
    a_vld = 1'b0;
    tick();
  endtask

  initial begin
    a_vld = 1'b1; a_dat = 32'hdead_beef; a_rdy = 1'b1;
    b_vld = 1'b1; b_dat = 32'hffff_ffff; b_rdy = 3'b111;
    RESET = 1'b1;

    // Reset: FIFO non-empty but never popped, all outputs cleared
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_a_ack", a_ack, 0);
      chk("rst_b_ack", b_ack, 0);
    end
    chk("rst_a_mv", a_mv, 0);
    chk("rst_a_msg", a_msg, 0);
    chk("rst_a_terr", a_terr, 0);
    chk("rst_a_cerr", a_cerr, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_mv", b_mv, 0);
    chk("rst_b_msg", b_msg, 0);
    chk("rst_b_cnt", b_cnt, 0);
    RESET = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    tick();
    chk("idle_a_mv", a_mv, 0);

    // START frame, back-to-back words
    a_word(32'h0000_0140);
    a_word(32'h0012_0000);
    a_word(32'h3c23_d70a);
    chk("start_mv", a_mv, 1);
    chk("start_msg", a_msg, 96'h3c23d70a_00120000_00000140);
    chk("start_no_pop", a_ack, 0);
    chk("start_cnt_pre", a_cnt, 0);
    a_vld = 1'b0;
    tick();
    chk("start_mv_clr", a_mv, 0);
    chk("start_cnt", a_cnt, 1);

    // Timeout: two words then silence; expiry on the 16th idle edge
    a_word(32'h1111_0000);
    a_word(32'h2222_0000);
    a_vld = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_quiet", a_terr, 0);
    end
    tick();
    chk("to_pulse", a_terr, 1);
    tick();
    chk("to_pulse_end", a_terr, 0);
    a_word(32'hb000_0000);
    a_word(32'hb111_1111);
    a_word(32'hb222_2222);
    chk("to_next_mv", a_mv, 1);
    chk("to_next_msg", a_msg, 96'hb2222222_b1111111_b0000000);
    a_vld = 1'b0;
    tick();
    chk("to_next_cnt", a_cnt, 2);

    // Third word lands on the expiry cycle: the pop wins
    a_word(32'hc000_0000);
    a_word(32'hc111_1111);
    a_vld = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    a_word(32'hc222_2222);
    chk("race_terr", a_terr, 0);
    chk("race_mv", a_mv, 1);
    chk("race_msg", a_msg, 96'hc2222222_c1111111_c0000000);
    a_vld = 1'b0;
    tick();
    chk("race_terr2", a_terr, 0);
    chk("race_cnt", a_cnt, 3);

    // Counter wrap on a 2-bit counter: 4th delivery -> 0, 5th -> 1
    a_frame(32'h0000_0400);
    chk("wrap_cnt0", a_cnt, 0);
    a_frame(32'h0000_0500);
    chk("wrap_cnt1", a_cnt, 1);

    // Reset while a command is waiting
    a_rdy = 1'b0;
    a_word(32'hd000_0000);
    a_word(32'hd000_0001);
    a_word(32'hd000_0002);
    a_vld = 1'b0;
    tick();
    tick();
    chk("rstd_held", a_mv, 1);
    RESET = 1'b1;
    tick();
    chk("rstd_mv", a_mv, 0);
    chk("rstd_cnt", a_cnt, 0);
    chk("rstd_msg", a_msg, 0);
    RESET = 1'b0; a_rdy = 1'b1;
    tick();
    tick();
    chk("rstd_no_mv", a_mv, 0);

    // Back-pressure on channel 1; other channels' ready must be ignored
    b_rdy = 3'b101;
    b_word(32'h4000_0000);
    b_word(32'h0000_0011);
    b_word(32'h0000_0022);
    chk("bp_mv", b_mv, 3'b010);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_mv_hold", b_mv, 3'b010);
      chk("bp_no_pop", b_ack, 0);
    end
    chk("bp_msg", b_msg, 96'h00000022_00000011_40000000);
    b_rdy = 3'b010;
    tick();
    chk("bp_mv_clr", b_mv, 0);
    chk("bp_cnt", b_cnt, 1);
    b_rdy = 3'b111;
    b_word(32'h0000_0005);
    b_word(32'h0000_0006);
    b_word(32'h0000_0007);
    chk("bp_next_mv", b_mv, 3'b001);
    b_vld = 1'b0;
    tick();
    chk("bp_next_cnt", b_cnt, 2);

    // Channel 3 with only three consumers: dropped with one chan_err pulse
    b_word(32'hc000_0000);
    b_word(32'h0000_0001);
    b_word(32'h0000_0002);
    b_vld = 1'b0;
    chk("bad_cerr", b_cerr, 1);
    chk("bad_mv", b_mv, 0);
    tick();
    chk("bad_cerr_end", b_cerr, 0);
    chk("bad_mv2", b_mv, 0);
    b_word(32'h8000_0007);
    b_word(32'h0000_0008);
    b_word(32'h0000_0009);
    chk("bad_next_mv", b_mv, 3'b100);
    chk("bad_next_msg", b_msg, 96'h00000009_00000008_80000007);
    b_vld = 1'b0;
    tick();
    chk("bad_next_cnt", b_cnt, 3);

    // Timeout disabled: a long gap inside a frame is tolerated
    b_word(32'h0000_0009);
    b_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("nto_quiet", b_terr, 0);
    end
    b_word(32'h0000_000a);
    b_word(32'h0000_000b);
    chk("nto_mv", b_mv, 3'b001);
    chk("nto_msg", b_msg, 96'h0000000b_0000000a_00000009);
    b_vld = 1'b0;
    tick();
    chk("nto_cnt", b_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
